// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 serial receiver with valid/ready byte output.
// Optional even-parity frame format (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5001
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    logic             rx_meta_q;
    logic             rxs_q;
    logic             rxs_prev_q;
    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [2:0]       idx_q,         idx_d;
    logic [7:0]       shift_q,       shift_d;
    logic [7:0]       rx_data_q,     rx_data_d;
    logic             rx_valid_q,    rx_valid_d;
    logic             frame_err_q,   frame_err_d;
    logic             overrun_err_q, overrun_err_d;
    logic             busy_q,        busy_d;
    logic             deliver_c;
    logic             accept_c;
`ifdef UART_RX_PARITY_EN
    logic             par_q,         par_d;
    logic             parity_err_q,  parity_err_d;
`endif

    // Synchronizer, edge history, FSM state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rxs_q         <= 1'b1;
            rxs_prev_q    <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q         <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q     <= rx;
            rxs_q         <= rx_meta_q;
            rxs_prev_q    <= rxs_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q         <= par_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // Frame FSM, bit timing, sampling and output handshake.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        shift_d       = shift_q;
        deliver_c     = 1'b0;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        rx_data_d     = rx_data_q;
        accept_c      = rx_valid_q & rx_ready;
        rx_valid_d    = rx_valid_q & ~accept_c;
`ifdef UART_RX_PARITY_EN
        par_d         = par_q;
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_q == CNT_LAST) begin
                    par_d   = rxs_q;
                    state_d = S_STOP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
`endif
                    end else begin
                        deliver_c = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A held byte that is accepted this cycle frees the slot for the new one.
        if (deliver_c) begin
            if (!rx_valid_q || accept_c) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed frames against an event-based receiver model.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 2 + CPB / 2 + (9 + PB) * CPB;
    localparam int K_GOOD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun_err(overrun_err),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // expected outcome of each frame: posedge index, kind, byte
    int         ev_cyc[$];
    int         ev_kind[$];
    logic [7:0] ev_dat[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic [7:0] got[$];
    logic       prev_v = 1'b0;
    int n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_busy = 0;

    logic [7:0] hello [12] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                               8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model update and per-cycle compare, 1 time unit after each posedge.
    always @(posedge clock) begin
        logic acc, ef, eo, ep;
        int k;
        logic [7:0] d;
        cyc = cyc + 1;
        #1;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            check("rst_valid", 32'(rx_valid), 0);
            check("rst_data", 32'(rx_data), 0);
            check("rst_ferr", 32'(frame_err), 0);
            check("rst_perr", 32'(parity_err), 0);
            check("rst_ovr", 32'(overrun_err), 0);
            check("rst_busy", 32'(busy), 0);
        end else begin
            acc = m_valid && rx_ready;
            ef = 1'b0; eo = 1'b0; ep = 1'b0;
            if (ev_cyc.size() != 0 && ev_cyc[0] == cyc) begin
                void'(ev_cyc.pop_front());
                k = ev_kind.pop_front();
                d = ev_dat.pop_front();
                if (k == K_GOOD) begin
                    if (!m_valid || acc) begin
                        m_valid = 1'b1;
                        m_data  = d;
                    end else begin
                        eo = 1'b1;
                    end
                end else begin
                    if (k == K_FERR) ef = 1'b1;
                    else             ep = 1'b1;
                    if (acc) m_valid = 1'b0;
                end
            end else if (acc) begin
                m_valid = 1'b0;
            end
            check("rx_valid", 32'(rx_valid), 32'(m_valid));
            if (m_valid) check("rx_data", 32'(rx_data), 32'(m_data));
            check("frame_err", 32'(frame_err), 32'(ef));
            check("overrun_err", 32'(overrun_err), 32'(eo));
            check("parity_err", 32'(parity_err), 32'(ep));
        end
        if (rx_valid && !prev_v) got.push_back(rx_data);
        prev_v = rx_valid;
        if (rx_valid)    n_vcyc++;
        if (frame_err)   n_ferr++;
        if (overrun_err) n_ovr++;
        if (parity_err)  n_perr++;
        if (busy)        n_busy++;
    end

    // All drive tasks start and end on a negedge.
    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic bits [11];
        int nb;
        int kind;
        kind = !stop_bit ? K_FERR : ((PB == 1 && par_flip) ? K_PERR : K_GOOD);
        ev_cyc.push_back(cyc + 1 + LAT);
        ev_kind.push_back(kind);
        ev_dat.push_back(b);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = b[i];
        nb = 9;
        if (PB == 1) begin
            bits[nb] = (^b) ^ par_flip;
            nb++;
        end
        bits[nb] = stop_bit;
        nb++;
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    initial begin
        int g0, v0, f0, o0, p0;
        logic [7:0] pb;
        rx = 1'b1;
        rx_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_data", 32'(rx_data), 0);
        check("reset_valid", 32'(rx_valid), 0);
        check("reset_busy", 32'(busy), 0);
        reset = 1'b0;
        idle_bits(2);

        // single frame, consumer always ready
        g0 = got.size(); v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h68, 1'b1, 1'b0);
        idle_bits(2);
        check("single_valid_cycles", 32'(n_vcyc - v0), 1);
        check("single_count", 32'(got.size() - g0), 1);
        check("single_byte", 32'(got[g0]), 32'h68);
        check("single_errs", 32'(n_ferr - f0 + n_ovr - o0), 0);

        // back-to-back frames, zero idle bits
        g0 = got.size(); f0 = n_ferr; o0 = n_ovr;
        for (int i = 0; i < 12; i++) send_frame(hello[i], 1'b1, 1'b0);
        idle_bits(2);
        check("hello_count", 32'(got.size() - g0), 12);
        for (int i = 0; i < 12; i++) check("hello_byte", 32'(got[g0 + i]), 32'(hello[i]));
        check("hello_errs", 32'(n_ferr - f0 + n_ovr - o0), 0);

        // short low glitch on idle line
        v0 = n_vcyc; f0 = n_ferr; n_busy = 0;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        idle_bits(2);
        check("glitch_busy_cycles", 32'(n_busy), 32'(CPB / 2));
        check("glitch_busy_end", 32'(busy), 0);
        check("glitch_no_valid", 32'(n_vcyc - v0), 0);
        check("glitch_no_ferr", 32'(n_ferr - f0), 0);

        // bad stop bit, then line held low (break)
        v0 = n_vcyc; f0 = n_ferr; g0 = got.size();
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clock);
        idle_bits(2);
        check("break_one_ferr", 32'(n_ferr - f0), 1);
        check("break_no_valid", 32'(n_vcyc - v0), 0);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_bits(2);
        check("after_break_count", 32'(got.size() - g0), 1);
        check("after_break_byte", 32'(got[g0]), 32'hA5);

        // overrun: consumer stalled for two frames
        o0 = n_ovr;
        rx_ready = 1'b0;
        send_frame(8'h68, 1'b1, 1'b0);
        send_frame(8'h65, 1'b1, 1'b0);
        idle_bits(2);
        check("ovr_pulses", 32'(n_ovr - o0), 1);
        check("ovr_held_data", 32'(rx_data), 32'h68);
        check("ovr_held_valid", 32'(rx_valid), 1);
        rx_ready = 1'b1;
        @(negedge clock);
        check("ovr_release_valid", 32'(rx_valid), 0);
        idle_bits(1);

        // reset in the middle of data bit 3
        pb = 8'h3C;
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            rx = pb[i];
            repeat (CPB) @(negedge clock);
        end
        rx = pb[3];
        repeat (CPB / 2) @(negedge clock);
        check("pre_reset_busy", 32'(busy), 1);
        reset = 1'b1;
        ev_cyc.delete(); ev_kind.delete(); ev_dat.delete();
        #1;
        check("mid_reset_busy", 32'(busy), 0);
        check("mid_reset_valid", 32'(rx_valid), 0);
        check("mid_reset_data", 32'(rx_data), 0);
        rx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle_bits(2);
        g0 = got.size();
        send_frame(8'h21, 1'b1, 1'b0);
        idle_bits(2);
        check("post_reset_count", 32'(got.size() - g0), 1);
        check("post_reset_byte", 32'(got[g0]), 32'h21);

`ifdef UART_RX_PARITY_EN
        // 0x68 has three ones, so a parity bit of 0 is a mismatch
        v0 = n_vcyc; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h68, 1'b1, 1'b1);
        idle_bits(2);
        check("parity_pulse", 32'(n_perr - p0), 1);
        check("parity_no_valid", 32'(n_vcyc - v0), 0);
        check("parity_no_ferr", 32'(n_ferr - f0), 0);
`else
        p0 = n_perr;
        check("parity_tied_low", 32'(p0), 0);
`endif

        check("events_consumed", 32'(ev_cyc.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
